// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared types and helpers for the pipeline hazard/stall controller.
// State encodings match the core's pipeline-control definitions (RUN=0, WAIT=1, ERR=2).
package hazard_stall_ctrl_pkg;

    typedef enum logic [1:0] {
        StRun  = 2'd0,
        StWait = 2'd1,
        StErr  = 2'd2
    } state_e;

    // Wide enough for the largest legal timeout (255).
    localparam int unsigned WaitCntW = 8;

    // True when the ID instruction reads a register the given stage will write.
    function automatic logic raw_check(input logic [4:0] src1,
                                       input logic [4:0] src2,
                                       input logic       two_src,
                                       input logic [4:0] dest,
                                       input logic       wb_en);
        return wb_en && ((src1 == dest) || (two_src && (src2 == dest)));
    endfunction

endpackage

// File: rtl/hazard_stall_ctrl_sat_counter.sv
// Saturating up-counter: counts cycles with inc=1 and sticks at all-ones.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Load-use / RAW stall detection, SRAM-wait pipeline freeze with timeout,
// deferred branch flush and saturating stall/freeze performance counters.
module hazard_stall_ctrl
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             forward_en,
    input  logic [4:0]       src1_ID,
    input  logic [4:0]       src2_ID,
    input  logic             two_src,
    input  logic [4:0]       dest_EXE,
    input  logic             WB_EN_EXE,
    input  logic             MEM_R_EN_EXE,
    input  logic [4:0]       dest_MEM,
    input  logic             WB_EN_MEM,
    input  logic             mem_req,
    input  logic             sram_ready,
    input  logic             branch_taken,
    output logic             hazard_stall,
    output logic             pipe_freeze,
    output logic             flush,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] freeze_cycles
);

    localparam logic [WaitCntW-1:0] WaitLast = WaitCntW'(MEM_TIMEOUT - 1);

    state_e              state_q, state_d;
    logic [WaitCntW-1:0] wait_cnt_q, wait_cnt_d;
    logic                flush_pend_q, flush_pend_d;
    logic                mem_timeout_q, mem_timeout_d;

    logic raw_exe, raw_mem, hazard;
    logic freeze_raw, flush_raw, stall_raw;

    assign raw_exe = raw_check(src1_ID, src2_ID, two_src, dest_EXE, WB_EN_EXE);
    assign raw_mem = raw_check(src1_ID, src2_ID, two_src, dest_MEM, WB_EN_MEM);

    // With forwarding only a load in EXE cannot be bypassed in time.
    assign hazard = forward_en ? (raw_exe && MEM_R_EN_EXE) : (raw_exe || raw_mem);

    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        mem_timeout_d = mem_timeout_q;
        freeze_raw    = 1'b0;
        case (state_q)
            StRun: begin
                freeze_raw = mem_req && !sram_ready;
                if (freeze_raw) begin
                    state_d    = StWait;
                    wait_cnt_d = {{(WaitCntW-1){1'b0}}, 1'b1};
                end
            end
            StWait: begin
                freeze_raw = !sram_ready;
                if (sram_ready) begin
                    state_d    = StRun;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == WaitLast) begin
                    state_d       = StErr;
                    mem_timeout_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + {{(WaitCntW-1){1'b0}}, 1'b1};
                end
            end
            StErr: begin
                freeze_raw = 1'b1;
            end
            default: begin
                state_d    = StRun;
                wait_cnt_d = '0;
            end
        endcase
    end

    assign flush_raw = (branch_taken || flush_pend_q) && !freeze_raw;
    assign stall_raw = hazard && !freeze_raw && !flush_raw;

    // A branch seen while frozen is remembered and issued exactly once afterwards.
    always_comb begin
        flush_pend_d = flush_pend_q;
        if (flush_raw) begin
            flush_pend_d = 1'b0;
        end else if (branch_taken && freeze_raw) begin
            flush_pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= StRun;
            wait_cnt_q    <= '0;
            flush_pend_q  <= 1'b0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            flush_pend_q  <= flush_pend_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    // Combinational controls are forced low for the whole reset window.
    assign pipe_freeze  = rst && freeze_raw;
    assign flush        = rst && flush_raw;
    assign hazard_stall = rst && stall_raw;
    assign mem_timeout  = mem_timeout_q;

    sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (hazard_stall),
        .cnt (stall_cycles)
    );

    sat_counter #(
        .W (CNT_W)
    ) u_freeze_cnt (
        .clk (clk),
        .rst (rst),
        .inc (pipe_freeze),
        .cnt (freeze_cycles)
    );

endmodule
